// File: rtl/game_outcome_controller.sv
// Per-frame game rules on top of the dragon collision checker's sticky flags.
// Optional high-score tracking is enabled by defining GAME_OUTCOME_HIGH_SCORE_EN.
module game_outcome_controller #(
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned LIVES_WIDTH   = 3,
  parameter int unsigned SCORE_WIDTH   = 10,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned INVULN_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_end,
  input  logic                   start,
  input  logic                   playerDragonCollision,
  input  logic                   swordDragonCollision,
  input  logic                   sheepDragonCollision,
  output logic [1:0]             gameState,
  output logic [LIVES_WIDTH-1:0] lives,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   playerHit,
  output logic                   dragonHit,
  output logic                   sheepEaten,
  output logic                   collisionClear
`ifdef GAME_OUTCOME_HIGH_SCORE_EN
  ,
  output logic [SCORE_WIDTH-1:0] highScore,
  output logic                   newHighScore
`endif
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPlaying  = 2'd1,
    StInvuln   = 2'd2,
    StGameOver = 2'd3
  } state_e;

  localparam logic [SCORE_WIDTH-1:0]  ScoreMax   = '1;
  localparam logic [LIVES_WIDTH-1:0]  LivesStart = LIVES_WIDTH'(START_LIVES);
  localparam logic [LIVES_WIDTH-1:0]  LivesOne   = LIVES_WIDTH'(1);
  localparam logic [INVULN_WIDTH-1:0] InvulnLoad = INVULN_WIDTH'(INVULN_FRAMES);
  localparam logic [INVULN_WIDTH-1:0] InvulnOne  = INVULN_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [LIVES_WIDTH-1:0]  lives_q, lives_d;
  logic [SCORE_WIDTH-1:0]  score_q, score_d;
  logic [INVULN_WIDTH-1:0] invuln_q, invuln_d;
  logic                    player_hit_q, player_hit_d;
  logic                    dragon_hit_q, dragon_hit_d;
  logic                    sheep_eaten_q, sheep_eaten_d;
  logic                    clear_q, clear_d;

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    score_d       = score_q;
    invuln_d      = invuln_q;
    player_hit_d  = 1'b0;
    dragon_hit_d  = 1'b0;
    sheep_eaten_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // start wins over a coincident frame_end; that frame's flags are dropped
        if (start) begin
          state_d = StPlaying;
          lives_d = LivesStart;
          score_d = '0;
        end
      end
      StPlaying, StInvuln: begin
        if (frame_end) begin
          if (swordDragonCollision) begin
            dragon_hit_d = 1'b1;
            if (score_q != ScoreMax) score_d = score_q + 1'b1;
          end
          if (sheepDragonCollision) sheep_eaten_d = 1'b1;
          if (state_q == StInvuln) begin
            invuln_d = invuln_q - 1'b1;
            if (invuln_q == InvulnOne) state_d = StPlaying;
          end else if (playerDragonCollision) begin
            player_hit_d = 1'b1;
            lives_d      = lives_q - 1'b1;
            if (lives_q == LivesOne) begin
              state_d = StGameOver;
            end else begin
              state_d  = StInvuln;
              invuln_d = InvulnLoad;
            end
          end
        end
      end
      StGameOver: begin
        if (start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flags are cleared after every consumed frame and held clear while not in play.
    clear_d = (state_d == StIdle) || (state_d == StGameOver) || frame_end;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      lives_q       <= '0;
      score_q       <= '0;
      invuln_q      <= '0;
      player_hit_q  <= 1'b0;
      dragon_hit_q  <= 1'b0;
      sheep_eaten_q <= 1'b0;
      clear_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      invuln_q      <= invuln_d;
      player_hit_q  <= player_hit_d;
      dragon_hit_q  <= dragon_hit_d;
      sheep_eaten_q <= sheep_eaten_d;
      clear_q       <= clear_d;
    end
  end

  assign gameState      = state_q;
  assign lives          = lives_q;
  assign score          = score_q;
  assign playerHit      = player_hit_q;
  assign dragonHit      = dragon_hit_q;
  assign sheepEaten     = sheep_eaten_q;
  assign collisionClear = clear_q;

`ifdef GAME_OUTCOME_HIGH_SCORE_EN
  logic [SCORE_WIDTH-1:0] high_q, high_d;
  logic                   new_high_q, new_high_d;

  // Uses score_d so the fatal frame's own sword hit counts toward the record.
  always_comb begin
    high_d     = high_q;
    new_high_d = 1'b0;
    if ((state_d == StGameOver) && (state_q != StGameOver) && (score_d > high_q)) begin
      high_d     = score_d;
      new_high_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      high_q     <= high_d;
      new_high_q <= new_high_d;
    end
  end

  assign highScore    = high_q;
  assign newHighScore = new_high_q;
`endif

endmodule

// File: doc/game_outcome_controller.md
Name: game_outcome_controller

Overview:
- Downstream consumer of the dragon collision checker's three sticky flags: playerDragonCollision, swordDragonCollision and sheepDragonCollision.
- Samples the flags once per frame at frame_end and applies game rules: lives, score, invulnerability window and game over.
- Drives collisionClear back to the collision checker's reset input, so the sticky flags are cleared for the next frame.
- Sits between the collision checker and the rendering/audio logic.

Parameters:
- START_LIVES, 3, lives loaded when a game starts; must be 1..2^LIVES_WIDTH-1.
- LIVES_WIDTH, 3, width of the lives output.
- SCORE_WIDTH, 10, width of the score output; score saturates at all-ones.
- INVULN_FRAMES, 60, frames of player-collision immunity after a hit; must be ≥1.
- INVULN_WIDTH, 6, width of the invulnerability frame counter; must satisfy INVULN_FRAMES < 2^INVULN_WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_end  in  1  one-cycle pulse; the collision flags are final for the frame on this cycle.
- start  in  1  one-cycle start/continue button pulse, debounced upstream.
- playerDragonCollision  in  1  sticky flag: player overlapped an active dragon segment.
- swordDragonCollision  in  1  sticky flag: sword overlapped a dragon segment.
- sheepDragonCollision  in  1  sticky flag: sheep overlapped a dragon segment.
- gameState  out  2  0=IDLE, 1=PLAYING, 2=INVULN, 3=GAME_OVER.
- lives  out  LIVES_WIDTH  remaining lives.
- score  out  SCORE_WIDTH  dragon hits this game.
- playerHit  out  1  one-cycle pulse: a life was lost.
- dragonHit  out  1  one-cycle pulse: the sword scored.
- sheepEaten  out  1  one-cycle pulse: the dragon reached the sheep.
- collisionClear  out  1  drives the collision checker's reset.

Behaviour:
- All outputs are registered.
- Reset values: gameState=IDLE, lives=0, score=0, playerHit=0, dragonHit=0, sheepEaten=0, collisionClear=1, invulnerability counter=0.
- Latency: a frame_end in cycle N produces state, lives, score and pulse updates in cycle N+1. Pulses last exactly one cycle.
- collisionClear:
  - Held at 1 in IDLE and GAME_OVER.
  - In PLAYING/INVULN it is 1 only in cycle N+1 after each frame_end, otherwise 0.
- IDLE:
  - start → PLAYING; lives=START_LIVES, score=0.
  - frame_end is ignored.
  - If start and frame_end arrive in the same cycle, start wins and that frame's flags are discarded.
- PLAYING, on frame_end:
  - swordDragonCollision: score+1, saturating at 2^SCORE_WIDTH-1; dragonHit pulses even when score is saturated.
  - sheepDragonCollision: sheepEaten pulses; score and lives unchanged.
  - playerDragonCollision: lives-1 and playerHit pulses.
    - If lives was 1: lives=0 → GAME_OVER.
    - Otherwise → INVULN, with the counter loaded to INVULN_FRAMES.
  - All three flags set at once: all three effects apply in the same cycle; score still increments on the fatal frame.
- INVULN, on frame_end:
  - Sword and sheep flags are handled as in PLAYING.
  - playerDragonCollision is ignored: no pulse, no life lost.
  - Counter decrements by 1; when the decremented value is 0 → PLAYING, effective from the next frame.
  - The frame that loads the counter does not count, so exactly INVULN_FRAMES later frames are immune.
- GAME_OVER:
  - lives and score are frozen; frame_end is ignored; no pulses.
  - start → IDLE; score is held until the next start from IDLE.
- start is ignored in PLAYING and INVULN.
- frame_end asserted on consecutive cycles: each pulse is a separate frame.
- Reset mid-game: next cycle shows the reset values; no pulse is emitted.

Optional Feature:
- Macro: GAME_OUTCOME_HIGH_SCORE_EN.
- When defined:
  - Extra output highScore (SCORE_WIDTH), reset to 0.
  - On entry to GAME_OVER, highScore = max(highScore, score), visible in the same cycle gameState becomes GAME_OVER.
  - Extra one-cycle pulse output newHighScore, asserted on that cycle only when score > old highScore.
  - highScore is cleared only by reset.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset, then start, then 3 frames with no flags → gameState=1, lives=3, score=0, no pulses, and collisionClear=1 exactly in the cycle after each frame_end.
- PLAYING with SCORE_WIDTH=4 and 17 frames with sword set → score reaches 15 and holds, dragonHit fires on all 17 frames.
- Player flag on frame 1 → lives=2, playerHit, gameState=2. Player flag on the next 60 frames → lives stays 2. Frame 62 with player flag → lives=1, gameState=2 again.
- lives=1 with player+sword+sheep on one frame → lives=0, score+1, all three pulses together, gameState=3, collisionClear held at 1. start → IDLE, then start → lives=3, score=0.
- In IDLE, start and frame_end in the same cycle with all flags set → PLAYING, lives=3, score=0, no pulses.
- Reset asserted in INVULN with counter at 30 → IDLE, lives=0, score=0. With GAME_OUTCOME_HIGH_SCORE_EN: a game ending at 7 then one ending at 5 → highScore=7, newHighScore fires only for the first game.
